// File: rtl/branch_predictor_table.sv
// branch_predictor_table: bimodal/gshare table of saturating direction counters
module branch_predictor_table #(
    parameter int CTR_W  = 2,
    parameter int IDX_W  = 4,
    parameter int HIST_W = 4,
    parameter int MODE   = 1,
    parameter int INIT   = 2**CTR_W-1,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [IDX_W-1:0]  req_pc,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [IDX_W-1:0]  pred_idx,
    input  logic              upd_valid,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic              upd_taken,
    input  logic              upd_pred,
    output logic [STAT_W-1:0] mispredict_cnt
);
    localparam int N    = 2**IDX_W;
    localparam int GH_W = (HIST_W > 0) ? HIST_W : 1;
    localparam logic [CTR_W-1:0] INIT_V = CTR_W'(INIT);

    logic [CTR_W-1:0]  ctr_q [N];
    logic [CTR_W-1:0]  ctr_d [N];
    logic [GH_W-1:0]   ghist_q, ghist_d;
    logic              pred_valid_q, pred_valid_d;
    logic              pred_taken_q, pred_taken_d;
    logic [IDX_W-1:0]  pred_idx_q, pred_idx_d;
    logic [STAT_W-1:0] stat_q, stat_d;
    logic [IDX_W-1:0]  idx;
    logic [CTR_W-1:0]  cur;

    // Lookup reads pre-update state; training and history/stat updates are computed alongside
    always_comb begin
        idx          = req_pc ^ ((MODE == 1 && HIST_W > 0) ? IDX_W'(ghist_q) : '0);
        pred_valid_d = req_valid;
        pred_taken_d = req_valid ? ctr_q[idx][CTR_W-1] : pred_taken_q;
        pred_idx_d   = req_valid ? idx : pred_idx_q;
        cur          = ctr_q[upd_idx];
        ctr_d        = ctr_q;
        if (upd_valid)
            ctr_d[upd_idx] = upd_taken ? (&cur ? cur : cur + 1'b1) : (|cur ? cur - 1'b1 : cur);
        ghist_d      = (upd_valid && HIST_W > 0) ? GH_W'({ghist_q, upd_taken}) : ghist_q;
        stat_d       = (upd_valid && upd_pred != upd_taken && !(&stat_q)) ? stat_q + 1'b1 : stat_q;
    end

    // State registers with asynchronous reset to the initial table/history/stat values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) ctr_q[i] <= INIT_V;
            ghist_q      <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= INIT_V[CTR_W-1];
            pred_idx_q   <= '0;
            stat_q       <= '0;
        end else begin
            ctr_q        <= ctr_d;
            ghist_q      <= ghist_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_idx_q   <= pred_idx_d;
            stat_q       <= stat_d;
        end
    end

    assign pred_valid     = pred_valid_q;
    assign pred_taken     = pred_taken_q;
    assign pred_idx       = pred_idx_q;
    assign mispredict_cnt = stat_q;
endmodule
